// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with transaction lock: one owner at a time, held for up to
// 'weight' last-beats, with priority rotating to the port after the previous owner.
module weighted_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 4,
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          last_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic [IDX_W-1:0]              gnt_idx_o,
    output logic                          busy_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]    credit_q, credit_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;

    logic [WEIGHT_W-1:0]    weight_arr [NUM_PORTS];
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         scan;
    logic [WEIGHT_W-1:0]    win_weight;
    logic [IDX_W-1:0]       owner_inc;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_weight
        assign weight_arr[gi] = weight_i[gi*WEIGHT_W +: WEIGHT_W];
    end

    // Scan from the far end back toward ptr so the last hit is the first port in rotation order.
    always_comb begin
        win_idx = '0;
        scan    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            scan = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (scan >= (IDX_W+1)'(NUM_PORTS)) begin
                scan = scan - (IDX_W+1)'(NUM_PORTS);
            end
            if (req_i[scan[IDX_W-1:0]]) begin
                win_idx = scan[IDX_W-1:0];
            end
        end
    end

    assign win_weight = weight_arr[win_idx];
    assign owner_inc  = (gnt_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            credit_q  <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        credit_d  = credit_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_idx_d        = win_idx;
                    credit_d         = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
                end
            end
            GRANT: begin
                // Abort takes precedence over last-beat accounting.
                if (!req_i[gnt_idx_q] || (last_i[gnt_idx_q] && credit_q <= WEIGHT_W'(1))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_inc;
                end else if (last_i[gnt_idx_q]) begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt_o     = gnt_q;
        gnt_idx_o = gnt_idx_q;
        busy_o    = |gnt_q;
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter: rotation order, weighted holds, wrap-around,
// abort, ignored non-owner strobes, zero weight, and asynchronous reset mid-grant.
module tb_weighted_rr_arbiter;

    localparam int NUM_PORTS = 4;
    localparam int WEIGHT_W  = 4;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_PORTS-1:0]          req_i;
    logic [NUM_PORTS-1:0]          last_i;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight_i;
    logic [NUM_PORTS-1:0]          gnt_o;
    logic [1:0]                    gnt_idx_o;
    logic                          busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    weighted_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .WEIGHT_W(WEIGHT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .last_i    (last_i),
        .weight_i  (weight_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    // Index is only meaningful while a grant is held, so it is compared only then.
    task automatic check_gnt(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_idx);
        check_eq({tag, ".gnt"}, 32'(gnt_o), 32'(exp_gnt));
        check_eq({tag, ".busy"}, 32'(busy_o), 32'(|exp_gnt));
        if (exp_gnt != 4'b0000) begin
            check_eq({tag, ".idx"}, 32'(gnt_idx_o), 32'(exp_idx));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq_gnt [8];
    logic [1:0] seq_idx [8];

    initial begin
        seq_gnt = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        seq_idx = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};

        reset    = 1'b1;
        req_i    = 4'b1111;
        last_i   = 4'b0000;
        weight_i = 16'h1111;
        tick();
        tick();
        check_gnt("reset", 4'b0000, 2'd0);
        check_eq("reset.idx", 32'(gnt_idx_o), 32'd0);

        reset = 1'b0;
        tick();
        check_gnt("first_grant", 4'b0001, 2'd0);

        // Every port requesting, weight 1, last always high: strict rotation with dead cycles.
        last_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_gnt($sformatf("rotate%0d", i), seq_gnt[i], seq_idx[i]);
        end
        req_i  = 4'b0000;
        last_i = 4'b0000;
        tick();
        check_gnt("abort_p0", 4'b0000, 2'd0);

        // Port1 weight 3: three last beats before release, then port0 gets one beat.
        weight_i = 16'h1131;
        req_i    = 4'b0011;
        tick();
        check_gnt("w3_grant", 4'b0010, 2'd1);
        last_i = 4'b0011;
        tick();
        check_gnt("w3_beat1", 4'b0010, 2'd1);
        tick();
        check_gnt("w3_beat2", 4'b0010, 2'd1);
        tick();
        check_gnt("w3_beat3", 4'b0000, 2'd0);
        tick();
        check_gnt("w1_p0", 4'b0001, 2'd0);
        tick();
        check_gnt("w1_p0_rel", 4'b0000, 2'd0);

        // Port2 owns, then ptr=3 wraps to port0; afterwards ptr=1 beats port0.
        req_i  = 4'b0100;
        last_i = 4'b0000;
        tick();
        check_gnt("p2_grant", 4'b0100, 2'd2);
        last_i = 4'b0100;
        tick();
        check_gnt("p2_rel", 4'b0000, 2'd0);
        req_i  = 4'b0001;
        last_i = 4'b0000;
        tick();
        check_gnt("wrap_p0", 4'b0001, 2'd0);
        last_i = 4'b0001;
        tick();
        check_gnt("wrap_rel", 4'b0000, 2'd0);
        req_i  = 4'b1111;
        last_i = 4'b0000;
        tick();
        check_gnt("ptr_after_wrap", 4'b0010, 2'd1);

        // Abort by owner port2; non-owner last strobes must not disturb the grant.
        req_i = 4'b0000;
        tick();
        check_gnt("abort_p1", 4'b0000, 2'd0);
        req_i = 4'b1100;
        tick();
        check_gnt("p2_again", 4'b0100, 2'd2);
        last_i = 4'b1011;
        tick();
        check_gnt("nonowner_last", 4'b0100, 2'd2);
        req_i  = 4'b1000;
        last_i = 4'b0000;
        tick();
        check_gnt("p2_abort", 4'b0000, 2'd0);
        tick();
        check_gnt("p3_after_abort", 4'b1000, 2'd3);

        // Asynchronous reset in the middle of a credit-2 grant.
        req_i = 4'b0000;
        tick();
        check_gnt("p3_abort", 4'b0000, 2'd0);
        weight_i = 16'h1211;
        req_i    = 4'b0100;
        tick();
        check_gnt("p2_w2", 4'b0100, 2'd2);
        #3 reset = 1'b1;
        #1;
        check_gnt("async_reset", 4'b0000, 2'd0);
        check_eq("async_reset.idx", 32'(gnt_idx_o), 32'd0);
        #2 reset = 1'b0;
        tick();
        check_gnt("post_reset_grant", 4'b0100, 2'd2);
        last_i = 4'b0100;
        tick();
        check_gnt("fresh_credit_hold", 4'b0100, 2'd2);
        tick();
        check_gnt("fresh_credit_rel", 4'b0000, 2'd0);

        // Weight 0 behaves as a single beat.
        weight_i = 16'h1210;
        req_i    = 4'b0001;
        last_i   = 4'b0001;
        tick();
        check_gnt("w0_grant", 4'b0001, 2'd0);
        tick();
        check_gnt("w0_rel", 4'b0000, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
